// File: rtl/shift_reg_univ.sv
// Universal WIDTH-bit shift register with a multi-cycle shift sequencer.
// Load/clear/hold complete in one cycle; shifts run one position per cycle under start/busy/done.
module shift_reg_univ #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [CNT_W-1:0] cnt,
    input  logic [WIDTH-1:0] din,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic             abort,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_LOAD = 3'b001,
        OP_SHL  = 3'b010,
        OP_SHR  = 3'b011,
        OP_ROL  = 3'b100,
        OP_ROR  = 3'b101,
        OP_ASR  = 3'b110,
        OP_CLR  = 3'b111
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e           state_reg;
    op_e              op_reg;
    logic [CNT_W-1:0] rem_reg;
    logic [WIDTH-1:0] q_reg;
    logic             done_reg;

    op_e              op_in;
    op_e              shift_op;
    logic             left_dir;
    logic             lsb_fill;
    logic             msb_fill;
    logic [WIDTH-1:0] q_shift;

    assign op_in = op_e'(op);

    // The first shift of a command happens on the accepting edge, so it uses the live op.
    assign shift_op = (state_reg == S_RUN) ? op_reg : op_in;
    assign left_dir = (shift_op == OP_SHL) || (shift_op == OP_ROL);

    always_comb begin
        lsb_fill = sin_r;
        msb_fill = sin_l;
        if (shift_op == OP_ROL) begin
            lsb_fill = q_reg[WIDTH-1];
        end
        if (shift_op == OP_ROR) begin
            msb_fill = q_reg[0];
        end else if (shift_op == OP_ASR) begin
            msb_fill = q_reg[WIDTH-1];
        end
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi == 0) begin : g_lsb
                assign q_shift[gi] = left_dir ? lsb_fill : q_reg[gi+1];
            end else if (gi == WIDTH - 1) begin : g_msb
                assign q_shift[gi] = left_dir ? q_reg[gi-1] : msb_fill;
            end else begin : g_mid
                assign q_shift[gi] = left_dir ? q_reg[gi-1] : q_reg[gi+1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            op_reg    <= OP_HOLD;
            rem_reg   <= '0;
            q_reg     <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        case (op_in)
                            OP_HOLD: done_reg <= 1'b1;
                            OP_LOAD: begin
                                q_reg    <= din;
                                done_reg <= 1'b1;
                            end
                            OP_CLR: begin
                                q_reg    <= '0;
                                done_reg <= 1'b1;
                            end
                            default: begin
                                if (cnt == '0) begin
                                    done_reg <= 1'b1;
                                end else begin
                                    q_reg <= q_shift;
                                    if (cnt == CNT_W'(1)) begin
                                        done_reg <= 1'b1;
                                    end else begin
                                        op_reg    <= op_in;
                                        rem_reg   <= cnt - CNT_W'(1);
                                        state_reg <= S_RUN;
                                    end
                                end
                            end
                        endcase
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        rem_reg   <= '0;
                        state_reg <= S_IDLE;
                    end else begin
                        q_reg   <= q_shift;
                        rem_reg <= rem_reg - CNT_W'(1);
                        if (rem_reg == CNT_W'(1)) begin
                            done_reg  <= 1'b1;
                            state_reg <= S_IDLE;
                        end
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign q      = q_reg;
    assign sout_l = q_reg[WIDTH-1];
    assign sout_r = q_reg[0];
    assign busy   = (state_reg == S_RUN);
    assign done   = done_reg;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed-vector bench for shift_reg_univ: handshake timing, every op, abort and reset mid-sequence.
module tb_shift_reg_univ;

    localparam int WIDTH = 16;
    localparam int CNT_W = 5;

    localparam logic [2:0] HOLD = 3'b000;
    localparam logic [2:0] LOAD = 3'b001;
    localparam logic [2:0] SHL  = 3'b010;
    localparam logic [2:0] SHR  = 3'b011;
    localparam logic [2:0] ROL  = 3'b100;
    localparam logic [2:0] ROR  = 3'b101;
    localparam logic [2:0] ASR  = 3'b110;
    localparam logic [2:0] CLR  = 3'b111;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [2:0]       op;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] din;
    logic             sin_l;
    logic             sin_r;
    logic             abort;
    logic [WIDTH-1:0] q;
    logic             sout_l;
    logic             sout_r;
    logic             busy;
    logic             done;

    int vec_cnt = 0;
    int err_cnt = 0;
    int busy_cyc;
    int done_cnt;

    shift_reg_univ #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .cnt    (cnt),
        .din    (din),
        .sin_l  (sin_l),
        .sin_r  (sin_r),
        .abort  (abort),
        .q      (q),
        .sout_l (sout_l),
        .sout_r (sout_r),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [CNT_W-1:0] c, input logic [WIDTH-1:0] d);
        start = 1'b1;
        op    = o;
        cnt   = c;
        din   = d;
        tick();
        start = 1'b0;
    endtask

    // Called right after the accepting edge; stops on the cycle where done is seen.
    task automatic run_to_done(output int b_cyc, output int d_cnt);
        b_cyc = 0;
        d_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            if (busy) b_cyc++;
            if (done) begin
                d_cnt++;
                break;
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op    = HOLD;
        cnt   = '0;
        din   = '0;
        sin_l = 1'b0;
        sin_r = 1'b0;
        abort = 1'b0;
        tick();
        tick();
        check("reset_q", 32'(q), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        rst_n = 1'b1;
        tick();

        // ROL then ROR by 4
        issue(LOAD, '0, 16'h8001);
        check("load_q", 32'(q), 32'h8001);
        check("load_done", 32'(done), 32'h1);
        issue(ROL, 5'd4, 16'h0000);
        run_to_done(busy_cyc, done_cnt);
        check("rol_busy_cycles", 32'(busy_cyc), 32'd3);
        check("rol_done", 32'(done_cnt), 32'd1);
        check("rol_q", 32'(q), 32'h0018);
        tick();
        check("rol_done_width", 32'(done), 32'h0);
        issue(ROR, 5'd4, 16'h0000);
        run_to_done(busy_cyc, done_cnt);
        check("ror_done", 32'(done_cnt), 32'd1);
        check("ror_q", 32'(q), 32'h8001);

        // ASR and SHR by 15
        issue(LOAD, '0, 16'h8000);
        issue(ASR, 5'd15, 16'h0000);
        run_to_done(busy_cyc, done_cnt);
        check("asr_busy_cycles", 32'(busy_cyc), 32'd14);
        check("asr_q", 32'(q), 32'hFFFF);
        issue(LOAD, '0, 16'h8000);
        sin_l = 1'b0;
        issue(SHR, 5'd15, 16'h0000);
        run_to_done(busy_cyc, done_cnt);
        check("shr_done", 32'(done_cnt), 32'd1);
        check("shr_q", 32'(q), 32'h0001);

        // SHL 16 with sin_r sampled live on each edge: 1,0,1,0,...
        issue(LOAD, '0, 16'h0000);
        sin_r = 1'b1;
        issue(SHL, 5'd16, 16'h0000);
        check("ser_sout_r_e0", 32'(sout_r), 32'h1);
        for (int i = 1; i < 16; i++) begin
            sin_r = (i % 2 == 0);
            tick();
            if (i == 14) check("ser_sout_l_e14", 32'(sout_l), 32'h0);
        end
        check("ser_sout_l_e15", 32'(sout_l), 32'h1);
        check("ser_q", 32'(q), 32'hAAAA);
        check("ser_done", 32'(done), 32'h1);
        check("ser_busy", 32'(busy), 32'h0);
        sin_r = 1'b0;

        // Abort at the 4th edge; start/din during RUN must be ignored
        issue(LOAD, '0, 16'h0001);
        issue(SHL, 5'd10, 16'h0000);
        start = 1'b1;
        op    = LOAD;
        din   = 16'hFFFF;
        tick();
        tick();
        check("abort_q_pre", 32'(q), 32'h0008);
        check("abort_busy_pre", 32'(busy), 32'h1);
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("abort_q", 32'(q), 32'h0008);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        tick();
        check("abort_done_after", 32'(done), 32'h0);
        check("abort_q_after", 32'(q), 32'h0008);

        // Edge cases: cnt=0, cnt=1, start on the done cycle, CLR, idle HOLD
        issue(SHL, 5'd0, 16'h0000);
        check("cnt0_q", 32'(q), 32'h0008);
        check("cnt0_done", 32'(done), 32'h1);
        check("cnt0_busy", 32'(busy), 32'h0);
        sin_r = 1'b1;
        issue(SHL, 5'd1, 16'h0000);
        sin_r = 1'b0;
        check("cnt1_q", 32'(q), 32'h0011);
        check("cnt1_done", 32'(done), 32'h1);
        check("cnt1_busy", 32'(busy), 32'h0);
        issue(ROL, 5'd1, 16'h0000);
        check("b2b_q", 32'(q), 32'h0022);
        check("b2b_done", 32'(done), 32'h1);
        issue(CLR, '0, 16'h0000);
        check("clr_q", 32'(q), 32'h0);
        check("clr_done", 32'(done), 32'h1);
        tick();
        check("idle_done", 32'(done), 32'h0);

        // start held high through a sequence is re-accepted once busy drops
        issue(LOAD, '0, 16'h0003);
        start = 1'b1;
        op    = SHL;
        cnt   = 5'd2;
        tick();
        check("held_e0_q", 32'(q), 32'h0006);
        check("held_e0_busy", 32'(busy), 32'h1);
        tick();
        check("held_e1_q", 32'(q), 32'h000C);
        check("held_e1_done", 32'(done), 32'h1);
        tick();
        start = 1'b0;
        check("held_e2_q", 32'(q), 32'h0018);
        check("held_e2_busy", 32'(busy), 32'h1);
        tick();
        check("held_e3_q", 32'(q), 32'h0030);
        check("held_e3_done", 32'(done), 32'h1);

        // Asynchronous reset mid-RUN
        issue(LOAD, '0, 16'hA5A5);
        issue(SHL, 5'd8, 16'h0000);
        tick();
        tick();
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_run_q", 32'(q), 32'h0);
        check("rst_run_busy", 32'(busy), 32'h0);
        tick();
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) done_cnt++;
        end
        check("rst_run_no_done", 32'(done_cnt), 32'd0);
        check("rst_run_q_after", 32'(q), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
